// File: rtl/conv_seq_pkg.sv
// Shared definitions for the complex convolution sequencer: state encoding,
// accumulator sizing and output saturation limits.
package conv_seq_pkg;

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_READY = 2'd1;
   localparam logic [1:0] ST_MAC   = 2'd2;
   localparam logic [1:0] ST_EMIT  = 2'd3;

   // Enough headroom that a sum of ntaps W-bit products can never wrap.
   function automatic int acc_width(input int w, input int ntaps);
      return w + $clog2(ntaps);
   endfunction

   function automatic int sat_hi(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_lo(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/conv_complex_sequencer_if.sv
// Stream-side signals of the convolution sequencer: coefficient load,
// sample input, result output and status.
interface conv_complex_sequencer_if #(
   parameter int W = 6
);
   logic                cfg_valid;
   logic                cfg_ready;
   logic signed [W-1:0] cfg_re;
   logic signed [W-1:0] cfg_im;
   logic                reload;
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] in_re;
   logic signed [W-1:0] in_im;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] out_re;
   logic signed [W-1:0] out_im;
   logic                out_ovf;
   logic                busy;

   modport master (
      output cfg_valid, cfg_re, cfg_im, reload, in_valid, in_re, in_im, out_ready,
      input  cfg_ready, in_ready, out_valid, out_re, out_im, out_ovf, busy
   );

   modport slave (
      input  cfg_valid, cfg_re, cfg_im, reload, in_valid, in_re, in_im, out_ready,
      output cfg_ready, in_ready, out_valid, out_re, out_im, out_ovf, busy
   );
endinterface

// File: rtl/mult_fixed_complex.sv
// Combinational signed fixed-point complex multiplier; product truncated
// (floor) back to QI.QF, ovf set when the truncated result does not fit.
module mult_fixed_complex #(
   parameter int QI = 3,
   parameter int QF = 3
) (
   input  logic signed [QI+QF-1:0] a_re,
   input  logic signed [QI+QF-1:0] a_im,
   input  logic signed [QI+QF-1:0] b_re,
   input  logic signed [QI+QF-1:0] b_im,
   output logic signed [QI+QF-1:0] p_re,
   output logic signed [QI+QF-1:0] p_im,
   output logic                    ovf
);
   localparam int W  = QI + QF;
   localparam int PW = 2 * W + 1;

   logic signed [PW-1:0] ar, ai, br, bi;
   logic signed [PW-1:0] full_re, full_im, sh_re, sh_im;

   assign ar = PW'(a_re);
   assign ai = PW'(a_im);
   assign br = PW'(b_re);
   assign bi = PW'(b_im);

   assign full_re = ar * br - ai * bi;
   assign full_im = ar * bi + ai * br;
   assign sh_re   = full_re >>> QF;
   assign sh_im   = full_im >>> QF;

   assign p_re = sh_re[W-1:0];
   assign p_im = sh_im[W-1:0];
   assign ovf  = (sh_re[PW-1:W-1] != {(PW-W+1){sh_re[W-1]}}) |
                 (sh_im[PW-1:W-1] != {(PW-W+1){sh_im[W-1]}});

endmodule

// File: rtl/conv_complex_sequencer.sv
// Time-multiplexed NTAPS-tap complex FIR around one shared complex multiplier.
// Build option CONV_SEQ_SAT_EN: defined = saturating output narrowing, undefined = wrapping.
//
// state | meaning
// LOAD  | taking NTAPS coefficient beats into h[]
// READY | waiting for a sample, or a reload request
// MAC   | idx 0..NTAPS: multiply tap idx, accumulate registered product of tap idx-1
// EMIT  | result held on out_* until downstream accepts
module conv_complex_sequencer
   import conv_seq_pkg::*;
#(
   parameter int QI    = 3,
   parameter int QF    = 3,
   parameter int NTAPS = 8
) (
   input logic                     clk,
   input logic                     rst_n,
   conv_complex_sequencer_if.slave bus
);
   localparam int W    = QI + QF;
   localparam int ACCW = acc_width(W, NTAPS);
   localparam int TW   = $clog2(NTAPS);
   localparam int IW   = $clog2(NTAPS + 1);

   logic [1:0]             state;
   logic [IW-1:0]          idx;
   logic [TW-1:0]          tap;
   logic signed [W-1:0]    h_re [NTAPS];
   logic signed [W-1:0]    h_im [NTAPS];
   logic signed [W-1:0]    x_re [NTAPS];
   logic signed [W-1:0]    x_im [NTAPS];
   logic signed [ACCW-1:0] acc_re, acc_im;
   logic                   ovf_acc;
   logic signed [W-1:0]    p_re, p_im, p_re_q, p_im_q;
   logic                   m_ovf, m_ovf_q;
   logic                   last_tap, cfg_fire, in_fire;
   logic [W:0]             nar_re, nar_im;

   assign last_tap = (idx == IW'(NTAPS - 1));
   assign tap      = (idx >= IW'(NTAPS)) ? '0 : idx[TW-1:0];
   assign cfg_fire = bus.cfg_valid & (state == ST_LOAD);
   assign in_fire  = bus.in_valid & (state == ST_READY);

   mult_fixed_complex #(.QI(QI), .QF(QF)) u_mult (
      .a_re (x_re[tap]),
      .a_im (x_im[tap]),
      .b_re (h_re[tap]),
      .b_im (h_im[tap]),
      .p_re (p_re),
      .p_im (p_im),
      .ovf  (m_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_LOAD;
         idx     <= '0;
         acc_re  <= '0;
         acc_im  <= '0;
         ovf_acc <= 1'b0;
         p_re_q  <= '0;
         p_im_q  <= '0;
         m_ovf_q <= 1'b0;
         for (int k = 0; k < NTAPS; k++) begin
            h_re[k] <= '0;
            h_im[k] <= '0;
            x_re[k] <= '0;
            x_im[k] <= '0;
         end
      end else begin
         case (state)
            ST_LOAD: begin
               if (cfg_fire) begin
                  h_re[tap] <= bus.cfg_re;
                  h_im[tap] <= bus.cfg_im;
                  if (last_tap) begin
                     state <= ST_READY;
                     idx   <= '0;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            ST_READY: begin
               if (in_fire) begin
                  for (int k = NTAPS - 1; k > 0; k--) begin
                     x_re[k] <= x_re[k-1];
                     x_im[k] <= x_im[k-1];
                  end
                  x_re[0] <= bus.in_re;
                  x_im[0] <= bus.in_im;
                  acc_re  <= '0;
                  acc_im  <= '0;
                  ovf_acc <= 1'b0;
                  idx     <= '0;
                  state   <= ST_MAC;
               end else if (bus.reload) begin
                  for (int k = 0; k < NTAPS; k++) begin
                     x_re[k] <= '0;
                     x_im[k] <= '0;
                  end
                  idx   <= '0;
                  state <= ST_LOAD;
               end
            end
            ST_MAC: begin
               // Product is registered, so accumulation trails the tap index by one.
               p_re_q  <= p_re;
               p_im_q  <= p_im;
               m_ovf_q <= m_ovf;
               if (idx != '0) begin
                  acc_re  <= acc_re + ACCW'(p_re_q);
                  acc_im  <= acc_im + ACCW'(p_im_q);
                  ovf_acc <= ovf_acc | m_ovf_q;
               end
               if (idx == IW'(NTAPS)) begin
                  idx   <= '0;
                  state <= ST_EMIT;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            ST_EMIT: begin
               if (bus.out_ready) state <= ST_READY;
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

`ifdef CONV_SEQ_SAT_EN
   localparam logic signed [ACCW-1:0] ACC_HI = ACCW'(sat_hi(W));
   localparam logic signed [ACCW-1:0] ACC_LO = ACCW'(sat_lo(W));

   function automatic logic [W:0] narrow(input logic signed [ACCW-1:0] a);
      if (a > ACC_HI)      return {1'b1, ACC_HI[W-1:0]};
      else if (a < ACC_LO) return {1'b1, ACC_LO[W-1:0]};
      else                 return {1'b0, a[W-1:0]};
   endfunction
`else
   function automatic logic [W:0] narrow(input logic signed [ACCW-1:0] a);
      return {(a[ACCW-1:W-1] != {(ACCW-W+1){a[W-1]}}), a[W-1:0]};
   endfunction
`endif

   assign nar_re = narrow(acc_re);
   assign nar_im = narrow(acc_im);

   assign bus.out_re    = nar_re[W-1:0];
   assign bus.out_im    = nar_im[W-1:0];
   assign bus.out_ovf   = ovf_acc | nar_re[W] | nar_im[W];
   assign bus.cfg_ready = (state == ST_LOAD);
   assign bus.in_ready  = (state == ST_READY);
   assign bus.out_valid = (state == ST_EMIT);
   assign bus.busy      = (state == ST_MAC) | (state == ST_EMIT);

endmodule

// File: tb/tb_conv_complex_sequencer.sv
// Self-checking bench for conv_complex_sequencer: spec vector table, corner
// sequences and random samples against an arithmetic convolution model.
module tb_conv_complex_sequencer;
   localparam int QI    = 3;
   localparam int QF    = 3;
   localparam int NTAPS = 8;
   localparam int W     = QI + QF;
   localparam int HI    = (1 << (W - 1)) - 1;
   localparam int LO    = -(1 << (W - 1));

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_complex_sequencer_if #(.W(W)) bus ();

   conv_complex_sequencer #(.QI(QI), .QF(QF), .NTAPS(NTAPS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int cur_hr [NTAPS];
   int cur_hi [NTAPS];
   int mh_re  [NTAPS];
   int mh_im  [NTAPS];
   int mx_re  [NTAPS];
   int mx_im  [NTAPS];

   typedef struct {
      int kern;
      int xr, xi;
      int er, ei;
      int eovf;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int wrapw(input int v);
      int r;
      r = v & ((1 << W) - 1);
      if (r > HI) r -= (1 << W);
      return r;
   endfunction

   // Reference convolution: y = sum_k trunc(x[k]*h[k]), then narrowed.
   task automatic model_out(output int ore, output int oim, output int oovf);
      int sr, si, fr, fi;
      sr = 0; si = 0; oovf = 0;
      for (int k = 0; k < NTAPS; k++) begin
         fr = (mx_re[k] * mh_re[k] - mx_im[k] * mh_im[k]) >>> QF;
         fi = (mx_re[k] * mh_im[k] + mx_im[k] * mh_re[k]) >>> QF;
         if (fr > HI || fr < LO || fi > HI || fi < LO) oovf = 1;
         sr += wrapw(fr);
         si += wrapw(fi);
      end
`ifdef CONV_SEQ_SAT_EN
      ore = (sr > HI) ? HI : ((sr < LO) ? LO : sr);
      oim = (si > HI) ? HI : ((si < LO) ? LO : si);
`else
      ore = wrapw(sr);
      oim = wrapw(si);
`endif
      if (ore != sr || oim != si) oovf = 1;
   endtask

   task automatic model_push(input int xr, input int xi);
      for (int k = NTAPS - 1; k > 0; k--) begin
         mx_re[k] = mx_re[k-1];
         mx_im[k] = mx_im[k-1];
      end
      mx_re[0] = xr;
      mx_im[0] = xi;
   endtask

   task automatic preset(input int p);
      for (int k = 0; k < NTAPS; k++) begin
         cur_hr[k] = (p == 3) ? 31 : 0;
         cur_hi[k] = 0;
      end
      if (p == 0) cur_hr[0] = 8;
      if (p == 1) cur_hr[3] = 8;
      if (p == 2) cur_hi[0] = 8;
   endtask

   task automatic load_kernel();
      if (!bus.cfg_ready) begin
         bus.reload = 1'b1;
         @(posedge clk); #1;
         bus.reload = 1'b0;
         chk("reload_to_load", int'(bus.cfg_ready), 1);
      end
      for (int k = 0; k < NTAPS; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         bus.cfg_valid = 1'b1;
         bus.cfg_re    = W'(cur_hr[k]);
         bus.cfg_im    = W'(cur_hi[k]);
         @(posedge clk); #1;
         bus.cfg_valid = 1'b0;
      end
      chk("load_done_in_ready", int'(bus.in_ready), 1);
      chk("load_done_cfg_ready", int'(bus.cfg_ready), 0);
      for (int k = 0; k < NTAPS; k++) begin
         mh_re[k] = cur_hr[k];
         mh_im[k] = cur_hi[k];
         mx_re[k] = 0;
         mx_im[k] = 0;
      end
   endtask

   // One sample through the pipe; holds out_ready low for 'hold' EMIT cycles.
   task automatic send(input int xr, input int xi, input int hold, input bit with_reload,
                       output int ore, output int oim, output int oovf, output int lat);
      int n;
      n = 0; ore = 0; oim = 0; oovf = 0; lat = 0;
      while (!bus.in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_wait", int'(bus.in_ready), 1);
      if (!bus.in_ready) return;
      bus.in_valid = 1'b1;
      bus.in_re    = W'(xr);
      bus.in_im    = W'(xi);
      bus.reload   = with_reload;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.reload   = 1'b0;
      model_push(xr, xi);
      if (with_reload) chk("sample_beats_reload", int'(bus.cfg_ready), 0);
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("out_valid_wait", int'(bus.out_valid), 1);
      if (!bus.out_valid) return;
      ore  = int'(bus.out_re);
      oim  = int'(bus.out_im);
      oovf = int'(bus.out_ovf);
      for (int c = 0; c < hold; c++) begin
         bus.reload    = 1'($urandom_range(0, 1));
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.cfg_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk("hold_re", int'(bus.out_re), ore);
         chk("hold_im", int'(bus.out_im), oim);
         chk("hold_ovf", int'(bus.out_ovf), oovf);
         chk("hold_valid", int'(bus.out_valid), 1);
         chk("hold_in_ready", int'(bus.in_ready), 0);
      end
      bus.reload    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("emit_release", int'(bus.out_valid), 0);
      chk("back_to_ready", int'(bus.in_ready), 1);
      chk("no_stray_load", int'(bus.cfg_ready), 0);
   endtask

   task automatic send_vs_model(input int xr, input int xi, input int hold, input bit rl);
      int r, i, o, lat, er, ei, eo;
      send(xr, xi, hold, rl, r, i, o, lat);
      model_out(er, ei, eo);
      chk("model_re", r, er);
      chk("model_im", i, ei);
      chk("model_ovf", o, eo);
      chk("latency", lat, NTAPS + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, i, o, lat, prev;

      tbl[0]  = '{0,   4,  -2,   4,  -2, 0};
      tbl[1]  = '{0, -32,  31, -32,  31, 0};
      tbl[2]  = '{1,   1,   0,   0,   0, 0};
      tbl[3]  = '{1,   2,   0,   0,   0, 0};
      tbl[4]  = '{1,   3,   0,   0,   0, 0};
      tbl[5]  = '{1,   4,   0,   1,   0, 0};
      tbl[6]  = '{1,   5,   0,   2,   0, 0};
      tbl[7]  = '{1,   6,   0,   3,   0, 0};
      tbl[8]  = '{2,   8,   0,   0,   8, 0};
      tbl[9]  = '{2,   0,   8,  -8,   0, 0};
      tbl[10] = '{2, -32,   0,   0, -32, 0};
      tbl[11] = '{2,   0, -32, -32,   0, 1};

      bus.cfg_valid = 1'b0; bus.cfg_re = '0; bus.cfg_im = '0; bus.reload = 1'b0;
      bus.in_valid  = 1'b0; bus.in_re  = '0; bus.in_im  = '0; bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_out_re", int'(bus.out_re), 0);
      chk("rst_out_im", int'(bus.out_im), 0);
      chk("rst_out_ovf", int'(bus.out_ovf), 0);

      prev = -1;
      for (int v = 0; v < 12; v++) begin
         if (tbl[v].kern != prev) begin
            preset(tbl[v].kern);
            load_kernel();
            prev = tbl[v].kern;
         end
         send(tbl[v].xr, tbl[v].xi, (v == 0) ? 5 : v % 3, 1'b0, r, i, o, lat);
         chk("tbl_re", r, tbl[v].er);
         chk("tbl_im", i, tbl[v].ei);
         chk("tbl_ovf", o, tbl[v].eovf);
         chk("tbl_latency", lat, NTAPS + 1);
      end

      // Reset while the MAC loop is at tap 3.
      preset(0);
      load_kernel();
      bus.in_valid = 1'b1; bus.in_re = W'(20); bus.in_im = W'(-9);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midmac_busy", int'(bus.busy), 0);
      chk("midmac_out_valid", int'(bus.out_valid), 0);
      chk("midmac_out_re", int'(bus.out_re), 0);
      chk("midmac_out_im", int'(bus.out_im), 0);
      chk("midmac_out_ovf", int'(bus.out_ovf), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midmac_cfg_ready", int'(bus.cfg_ready), 1);
      chk("midmac_in_ready", int'(bus.in_ready), 0);
      load_kernel();
      send_vs_model(3, 5, 1, 1'b0);

      // All taps 31 with full history of 1.0.
      preset(3);
      load_kernel();
      for (int s = 0; s < NTAPS; s++) begin
         send(8, 0, 0, 1'b0, r, i, o, lat);
         model_out(prev, lat, lat);
         chk("sat_fill_re", r, prev);
      end
`ifdef CONV_SEQ_SAT_EN
      chk("sat_re", r, 31);
`else
      chk("sat_re", r, -8);
`endif
      chk("sat_im", i, 0);
      chk("sat_ovf", o, 1);

      send_vs_model(8, 0, 2, 1'b1);

      for (int kr = 0; kr < 3; kr++) begin
         for (int k = 0; k < NTAPS; k++) begin
            cur_hr[k] = int'($urandom_range(0, 63)) - 32;
            cur_hi[k] = int'($urandom_range(0, 63)) - 32;
         end
         load_kernel();
         for (int s = 0; s < 10; s++)
            send_vs_model(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
                          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
